trap_unit: RTL and testbench

TRAP_UNIT -- requirements
Module: trap_unit

---
 rtl/trap_unit.sv | 97 +++++++++
 tb/tb_trap_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap/return sequencer with fetch redirect handshake (vectored irq targets when TRAP_VECTORED_EN is defined)
module trap_unit #(
    parameter int XLEN          = 32,
    parameter int NUM_IRQ       = 4,
    parameter int IRQ_CODE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pipe_flush,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    int_pc,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               mie_wr,
    input  logic               mie_wdata,
    input  logic [XLEN-1:0]    mtvec,
    output logic               redirect_valid,
    input  logic               redirect_ready,
    output logic [XLEN-1:0]    redirect_target,
    output logic [XLEN-1:0]    mepc,
    output logic [XLEN-1:0]    mcause,
    output logic               mie,
    output logic               mpie,
    output logic               busy
);
    typedef enum logic {IDLE, REDIRECT} state_t;
    localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
    state_t              state;
    logic [NUM_IRQ-1:0]  pend;
    logic                irq_hit, open, take_exc, take_ret, take_irq;
    logic [XLEN-1:0]     irq_code, irq_target, base;
    assign pend     = irq & irq_mask;
    assign base     = mtvec & ALIGN;
    assign open     = state == IDLE && !pipe_flush;
    assign take_exc = open && exc_valid;
    assign take_ret = open && !exc_valid && mret;
    assign take_irq = open && !exc_valid && !mret && mie && irq_hit;
    assign busy     = state == REDIRECT;
`ifdef TRAP_VECTORED_EN
    assign irq_target = base + (irq_code << 2);
`else
    assign irq_target = base;
`endif
    // pick the lowest-index enabled line (descending scan, last hit wins)
    always_comb begin
        irq_hit  = 1'b0;
        irq_code = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) begin
                irq_hit  = 1'b1;
                irq_code = XLEN'(IRQ_CODE_BASE + i);
            end
    end
    // trap/return acceptance, CSR updates and redirect handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            redirect_valid  <= 1'b0;
            redirect_target <= '0;
            mepc            <= '0;
            mcause          <= '0;
            mie             <= 1'b0;
            mpie            <= 1'b0;
        end else if (take_exc) begin
            state           <= REDIRECT;
            redirect_valid  <= 1'b1;
            redirect_target <= base;
            mepc            <= exc_pc & ALIGN;
            mcause          <= XLEN'(exc_cause);
            mpie            <= mie;
            mie             <= 1'b0;
        end else if (take_ret) begin
            state           <= REDIRECT;
            redirect_valid  <= 1'b1;
            redirect_target <= mepc;
            mie             <= mpie;
            mpie            <= 1'b1;
        end else if (take_irq) begin
            state           <= REDIRECT;
            redirect_valid  <= 1'b1;
            redirect_target <= irq_target;
            mepc            <= int_pc & ALIGN;
            mcause          <= {1'b1, irq_code[XLEN-2:0]};
            mpie            <= mie;
            mie             <= 1'b0;
        end else begin
            if (mie_wr) mie <= mie_wdata;
            if (state == REDIRECT && redirect_ready) begin
                state          <= IDLE;
                redirect_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed self-checking bench for trap_unit
module tb_trap_unit;
    logic        clk = 1'b0;
    logic        rst_n, pipe_flush, exc_valid, mret, mie_wr, mie_wdata, redirect_ready;
    logic [3:0]  exc_cause, irq, irq_mask;
    logic [31:0] exc_pc, int_pc, mtvec;
    logic        redirect_valid, mie, mpie, busy;
    logic [31:0] redirect_target, mepc, mcause;
    int checks = 0, errors = 0;

    trap_unit dut (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_pc(exc_pc), .int_pc(int_pc), .mret(mret),
        .irq(irq), .irq_mask(irq_mask), .mie_wr(mie_wr), .mie_wdata(mie_wdata),
        .mtvec(mtvec), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_target(redirect_target), .mepc(mepc), .mcause(mcause),
        .mie(mie), .mpie(mpie), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(redirect_valid), 0);
        chk({tag, " target"}, redirect_target, 0);
        chk({tag, " mepc"}, mepc, 0);
        chk({tag, " mcause"}, mcause, 0);
        chk({tag, " mie"}, 32'(mie), 0);
        chk({tag, " mpie"}, 32'(mpie), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n = 0; pipe_flush = 0; exc_valid = 0; mret = 0; mie_wr = 0; mie_wdata = 0;
        redirect_ready = 1; exc_cause = 0; irq = 0; irq_mask = 0;
        exc_pc = 0; int_pc = 0; mtvec = 32'h100;
        tick; tick;
        chk_zero("reset");
        rst_n = 1;

        mie_wr = 1; mie_wdata = 1; tick; mie_wr = 0;
        chk("sw mie write", 32'(mie), 1);

        redirect_ready = 0;
        exc_valid = 1; exc_cause = 2; exc_pc = 32'h2002; tick; exc_valid = 0;
        chk("exc valid", 32'(redirect_valid), 1);
        chk("exc target", redirect_target, 32'h100);
        chk("exc mepc", mepc, 32'h2000);
        chk("exc mcause", mcause, 2);
        chk("exc mie", 32'(mie), 0);
        chk("exc mpie", 32'(mpie), 1);
        chk("exc busy", 32'(busy), 1);

        for (int i = 0; i < 3; i++) begin
            exc_valid = (i == 1); exc_cause = 5; exc_pc = 32'h3000;
            tick;
            chk("bp valid", 32'(redirect_valid), 1);
            chk("bp target", redirect_target, 32'h100);
            chk("bp mepc", mepc, 32'h2000);
            chk("bp mcause", mcause, 2);
        end
        exc_valid = 0; redirect_ready = 1; tick;
        chk("bp release valid", 32'(redirect_valid), 0);
        chk("bp release busy", 32'(busy), 0);

        mret = 1; tick; mret = 0;
        chk("mret target", redirect_target, 32'h2000);
        chk("mret mie", 32'(mie), 1);
        chk("mret mpie", 32'(mpie), 1);
        chk("mret mepc kept", mepc, 32'h2000);
        chk("mret mcause kept", mcause, 2);
        tick;
        chk("mret idle", 32'(busy), 0);

        irq = 4'b0110; irq_mask = 4'b1111; int_pc = 32'h400; tick; irq = 0;
        chk("irq mcause", mcause, 32'h8000_0011);
        chk("irq mepc", mepc, 32'h400);
`ifdef TRAP_VECTORED_EN
        chk("irq target", redirect_target, 32'h144);
`else
        chk("irq target", redirect_target, 32'h100);
`endif
        chk("irq mie", 32'(mie), 0);
        chk("irq mpie", 32'(mpie), 1);
        tick;
        mret = 1; tick; mret = 0;
        chk("irq ret target", redirect_target, 32'h400);
        chk("irq ret mie", 32'(mie), 1);
        chk("irq ret mpie", 32'(mpie), 1);
        chk("irq ret mcause kept", mcause, 32'h8000_0011);
        tick;

        mtvec = 32'hFFFF_FFF0; irq = 4'b1001; irq_mask = 4'b1110; int_pc = 32'h807;
        tick; irq = 0;
        chk("mask mcause", mcause, 32'h8000_0013);
        chk("mask mepc", mepc, 32'h804);
`ifdef TRAP_VECTORED_EN
        chk("wrap target", redirect_target, 32'h0000_003C);
`else
        chk("wrap target", redirect_target, 32'hFFFF_FFF0);
`endif
        tick; mtvec = 32'h100;
        mret = 1; tick; mret = 0;
        chk("mask ret target", redirect_target, 32'h804);
        tick;

        pipe_flush = 1; exc_valid = 1; exc_cause = 7; exc_pc = 32'h5000; mret = 1;
        irq = 4'b0001; irq_mask = 4'b1111;
        tick;
        chk("flush busy", 32'(busy), 0);
        chk("flush valid", 32'(redirect_valid), 0);
        chk("flush mepc", mepc, 32'h804);
        chk("flush mie", 32'(mie), 1);
        pipe_flush = 0; tick;
        exc_valid = 0; mret = 0; irq = 0;
        chk("simul mcause", mcause, 7);
        chk("simul mepc", mepc, 32'h5000);
        chk("simul target", redirect_target, 32'h100);
        chk("simul mie", 32'(mie), 0);
        chk("simul mpie", 32'(mpie), 1);
        tick;
        chk("simul idle", 32'(busy), 0);

        irq = 4'b0001; tick; irq = 0;
        chk("irq gated by mie", 32'(busy), 0);

        mret = 1; mie_wr = 1; mie_wdata = 0; tick; mret = 0; mie_wr = 0;
        chk("accept over sw write", 32'(mie), 1);
        chk("accept over sw busy", 32'(busy), 1);
        tick;

        redirect_ready = 0; exc_valid = 1; exc_cause = 3; exc_pc = 32'h6000; tick; exc_valid = 0;
        chk("pre-reset busy", 32'(busy), 1);
        #2 rst_n = 0;
        #1 chk_zero("async reset");
        tick; rst_n = 1; redirect_ready = 1; tick;
        chk("post reset busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
